regfile_wb_arbiter: RTL

- Shares the single register-file write port between two writeback requesters: req0 = ALU/EX result, req1 = LSU/load result.
- Per-requester valid/ready handshake with round-robin arbitration on conflict.
- Registered write stage drives the regfile write port (write/waddr1/din).
- Write-stage forwarding onto both read ports covers the cycle before the regfile write edge lands.

---
 rtl/regfile_wb_arbiter_pkg.sv | 16 +
 rtl/regfile_wb_arbiter_rr_arb2.sv | 45 ++++
 rtl/regfile_wb_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: bus widths matching RegBus and
// RegAddrBus, reset level, zero word and the writeback source encoding.
package regfile_wb_arbiter_pkg;

  localparam int RegBusW     = 32;
  localparam int RegAddrBusW = 5;

  localparam logic [RegBusW-1:0] ZeroWord  = '0;
  localparam logic               RstEnable = 1'b1;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-requester round-robin grant. The priority pointer only moves on a
// contested grant and then points at the loser, so a held loser is served on
// the next enabled cycle. Grants are purely combinational from the requests.
module regfile_wb_arbiter_rr_arb2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic prio_q;
  logic prio_d;

  // Grant selection and pointer update for the next cycle
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    prio_d = prio_q;
    if ((rst != RstEnable) && en) begin
      if (req0 && (!req1 || !prio_q)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
      if (req0 && req1) begin
        prio_d = gnt0;
      end
    end
  end

  // Priority pointer register, ALU first out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single regfile write port between the ALU (req0) and LSU (req1)
// writeback paths. One registered write stage drives the regfile; its contents
// are bypassed onto both read ports for the cycle before the write lands.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = RegBusW,
  parameter int ADDR_W = RegAddrBusW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_src,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              fwd_hit1,
  output logic [DATA_W-1:0] fwd_data1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data2,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic gnt0;
  logic gnt1;

  logic              wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  wb_src_e           wr_src_q,  wr_src_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;

  regfile_wb_arbiter_rr_arb2 u_rr_arb2 (
    .clk  (clk),
    .rst  (rst),
    .en   (!freeze),
    .req0 (req0_valid),
    .req1 (req1_valid),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Next write-stage contents: load the winner, otherwise drop wr_en and hold fields
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_src_d  = wr_src_q;
    if (gnt0) begin
      wr_en_d   = 1'b1;
      wr_addr_d = req0_addr;
      wr_data_d = req0_data;
      wr_src_d  = SRC_ALU;
    end else if (gnt1) begin
      wr_en_d   = 1'b1;
      wr_addr_d = req1_addr;
      wr_data_d = req1_data;
      wr_src_d  = SRC_LSU;
    end
  end

  // Saturating count of unfrozen cycles with both requesters valid
  always_comb begin
    cnt_d = cnt_q;
    if (req0_valid && req1_valid && !freeze && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Write stage and counter registers; reset clears the in-flight write too
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= DATA_W'(ZeroWord);
      wr_src_q  <= SRC_ALU;
      cnt_q     <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_src_q  <= wr_src_d;
      cnt_q     <= cnt_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign wr_src       = wr_src_q;
  assign conflict_cnt = cnt_q;

  // Bypass the pending write onto each read port independently
  always_comb begin
    fwd_hit1  = wr_en_q && (wr_addr_q == rd_addr1);
    fwd_hit2  = wr_en_q && (wr_addr_q == rd_addr2);
    fwd_data1 = fwd_hit1 ? wr_data_q : '0;
    fwd_data2 = fwd_hit2 ? wr_data_q : '0;
  end

endmodule
